// File: rtl/pair_queue.sv
// Receive-side queue for filtered particle pairs: drops null pairs, buffers the rest in a FWFT FIFO
// and flags the end of a reference sweep. Optional statistics counters are enabled by PAIR_QUEUE_STATS_EN.
module pair_queue #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W:0]   pair_i,
  input  logic                pair_valid_i,
  input  logic                pair_last_i,
  output logic                in_ready_o,
  output logic [DATA_W-1:0]   ref_o,
  output logic [DATA_W-1:0]   nbr_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CNT_W-1:0]    count_o,
  output logic                done_o,
  output logic                err_o,
  output logic [31:0]         acc_cnt_o,
  output logic [31:0]         drop_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               in_ready;
  logic               take;
  logic               is_null;
  logic               wr_en;
  logic               out_valid;
  logic               pop;
  logic               done;
  logic [ENTRY_W-1:0] head;

  // Handshakes: a word transfers on a cycle where its valid and the matching ready are both high;
  // valid never depends on ready, and the head word holds while out_valid_o is high without out_ready_i.
  always_comb begin
    in_ready  = (count_q != FULL_CNT) && (state_q != ST_DRAIN);
    take      = pair_valid_i && in_ready;
    is_null   = pair_i[2*DATA_W];
    wr_en     = take && !is_null;
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // No writes are accepted in DRAIN, so count_d here only reflects pops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = pair_last_i ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (take && pair_last_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done  = (state_q == ST_DRAIN) && (count_d == '0);
    err_d = err_q || (pair_valid_i && !in_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; the output mux below hides stale contents while the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= pair_i[ENTRY_W-1:0];
    end
  end

  always_comb begin
    head = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign ref_o       = head[ENTRY_W-1:DATA_W];
  assign nbr_o       = head[DATA_W-1:0];
  assign count_o     = count_q;
  assign done_o      = done;
  assign err_o       = err_q;

`ifdef PAIR_QUEUE_STATS_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] drop_q, drop_d;
  logic [31:0] acc_base, drop_base;
  logic        leave_idle;

  // Counters restart when a new sweep begins; the word that starts the sweep is still counted.
  always_comb begin
    leave_idle = (state_q == ST_IDLE) && take;
    acc_base   = leave_idle ? '0 : acc_q;
    drop_base  = leave_idle ? '0 : drop_q;
    acc_d      = acc_base;
    drop_d     = drop_base;
    if (wr_en && (acc_base != 32'hFFFF_FFFF)) begin
      acc_d = acc_base + 32'd1;
    end
    if (take && is_null && (drop_base != 32'hFFFF_FFFF)) begin
      drop_d = drop_base + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end

  assign acc_cnt_o  = acc_q;
  assign drop_cnt_o = drop_q;
`else
  assign acc_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pair_queue.sv
// Directed bench for pair_queue: reset, null filtering, full/backpressure, wrap, sweep end and null-last.
module tb_pair_queue;

  localparam int DW    = 96;
  localparam int CW    = 5;
  localparam int EW    = 2 * DW;
`ifdef PAIR_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [2*DW:0]   pair_i;
  logic            pair_valid_i;
  logic            pair_last_i;
  logic            in_ready_o;
  logic [DW-1:0]   ref_o;
  logic [DW-1:0]   nbr_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [CW-1:0]   count_o;
  logic            done_o;
  logic            err_o;
  logic [31:0]     acc_cnt_o;
  logic [31:0]     drop_cnt_o;

  int              checks = 0;
  int              errors = 0;
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   exp_w;
  int              pops;
  int              dones;

  pair_queue #(.DATA_W(DW), .DEPTH(16), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pair_i       (pair_i),
    .pair_valid_i (pair_valid_i),
    .pair_last_i  (pair_last_i),
    .in_ready_o   (in_ready_o),
    .ref_o        (ref_o),
    .nbr_o        (nbr_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .count_o      (count_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .acc_cnt_o    (acc_cnt_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] mk_ref(input int id);
    return {32'h1000_0000 + 32'(id), 32'h2000_0000 + 32'(id), 32'h3000_0000 + 32'(id)};
  endfunction

  function automatic logic [DW-1:0] mk_nbr(input int id);
    return {32'h4000_0000 + 32'(id), 32'h5000_0000 + 32'(id), 32'h6000_0000 + 32'(id)};
  endfunction

  // driver tasks: called just after a rising edge
  task automatic drive(input logic v, input logic nul, input logic last, input int id, input logic ordy);
    pair_valid_i = v;
    pair_last_i  = last;
    pair_i       = {nul, mk_ref(id), mk_nbr(id)};
    out_ready_i  = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({count_o, out_valid_o, in_ready_o, done_o, err_o} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got cnt=%0d ov=%b ir=%b done=%b err=%b expected cnt=0 ov=0 ir=1 done=0 err=0",
               count_o, out_valid_o, in_ready_o, done_o, err_o);
    end
    checks++;
    if ({ref_o, nbr_o, acc_cnt_o, drop_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got ref=%h nbr=%h acc=%0d drop=%0d expected all zero", ref_o, nbr_o, acc_cnt_o, drop_cnt_o);
    end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 100 + i, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (count_o !== 5'd5) begin
      errors++;
      $display("FAIL reset_fill: got count=%0d expected 5", count_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({count_o, out_valid_o, in_ready_o, err_o, done_o} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got cnt=%0d ov=%b ir=%b err=%b done=%b expected cnt=0 ov=0 ir=1 err=0 done=0",
               count_o, out_valid_o, in_ready_o, err_o, done_o);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid_o, done_o, ref_o} !== {1'b0, 1'b0, 96'd0}) begin
      errors++;
      $display("FAIL reset_after: got ov=%b done=%b ref=%h expected ov=0 done=0 ref=0", out_valid_o, done_o, ref_o);
    end
    next_cycle();
  endtask

  task automatic test_filter_drop();
    apply_reset();
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        drive(1'b1, (i % 2 == 0), 1'b0, 200 + i, 1'b1);
        if (i % 2 == 1) exp_q.push_back({mk_ref(200 + i), mk_nbr(200 + i)});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      end
      @(negedge clk);
      if (out_valid_o) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL drop_extra: got %h expected no word", {ref_o, nbr_o});
        end else begin
          exp_w = exp_q.pop_front();
          if ({ref_o, nbr_o} !== exp_w) begin
            errors++;
            $display("FAIL drop_data: got %h expected %h", {ref_o, nbr_o}, exp_w);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if (pops !== 4) begin
      errors++;
      $display("FAIL drop_pops: got %0d expected 4", pops);
    end
    checks++;
    if ({acc_cnt_o, drop_cnt_o} !== {(STATS ? 32'd4 : 32'd0), (STATS ? 32'd4 : 32'd0)}) begin
      errors++;
      $display("FAIL drop_stats: got acc=%0d drop=%0d expected %0d/%0d", acc_cnt_o, drop_cnt_o,
               STATS ? 4 : 0, STATS ? 4 : 0);
    end
  endtask

  task automatic test_full();
    apply_reset();
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 300 + i, 1'b0);
      exp_q.push_back({mk_ref(300 + i), mk_nbr(300 + i)});
      @(negedge clk);
      checks++;
      if (in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL full_ready_%0d: got %b expected 1", i, in_ready_o);
      end
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 399, 1'b0);
    @(negedge clk);
    checks++;
    if ({count_o, in_ready_o, err_o} !== {5'd16, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL full_state: got cnt=%0d ir=%b err=%b expected cnt=16 ir=0 err=0", count_o, in_ready_o, err_o);
    end
    checks++;
    if ({ref_o, nbr_o} !== {mk_ref(300), mk_nbr(300)}) begin
      errors++;
      $display("FAIL full_hold: got %h expected %h", {ref_o, nbr_o}, {mk_ref(300), mk_nbr(300)});
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if ({err_o, count_o} !== {1'b1, 5'd16}) begin
      errors++;
      $display("FAIL full_err: got err=%b cnt=%0d expected err=1 cnt=16", err_o, count_o);
    end
    next_cycle();
    for (int c = 0; c < 24; c++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      @(negedge clk);
      if (out_valid_o) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL full_extra: got %h expected no word", {ref_o, nbr_o});
        end else begin
          exp_w = exp_q.pop_front();
          if ({ref_o, nbr_o} !== exp_w) begin
            errors++;
            $display("FAIL full_data: got %h expected %h", {ref_o, nbr_o}, exp_w);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if ({pops, count_o, err_o} !== {32'd16, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL full_drain: got pops=%0d cnt=%0d err=%b expected 16/0/1", pops, count_o, err_o);
    end
    checks++;
    if (acc_cnt_o !== (STATS ? 32'd16 : 32'd0)) begin
      errors++;
      $display("FAIL full_acc: got %0d expected %0d", acc_cnt_o, STATS ? 16 : 0);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", err_o);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pops = 0;
    for (int i = 0; i < 43; i++) begin
      if (i < 40) begin
        drive(1'b1, 1'b0, 1'b0, 400 + i, 1'b1);
        exp_q.push_back({mk_ref(400 + i), mk_nbr(400 + i)});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      end
      @(negedge clk);
      if (i < 40) begin
        checks++;
        if (count_o !== ((i == 0) ? 5'd0 : 5'd1)) begin
          errors++;
          $display("FAIL wrap_count_%0d: got %0d expected %0d", i, count_o, (i == 0) ? 0 : 1);
        end
      end
      if (out_valid_o) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra: got %h expected no word", {ref_o, nbr_o});
        end else begin
          exp_w = exp_q.pop_front();
          if ({ref_o, nbr_o} !== exp_w) begin
            errors++;
            $display("FAIL wrap_data: got %h expected %h", {ref_o, nbr_o}, exp_w);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if ({pops, count_o} !== {32'd40, 5'd0}) begin
      errors++;
      $display("FAIL wrap_total: got pops=%0d cnt=%0d expected 40/0", pops, count_o);
    end
  endtask

  task automatic test_sweep_end();
    apply_reset();
    pops  = 0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, (i == 2), 500 + i, 1'b0);
      exp_q.push_back({mk_ref(500 + i), mk_nbr(500 + i)});
      @(negedge clk);
      checks++;
      if ({in_ready_o, done_o} !== 2'b10) begin
        errors++;
        $display("FAIL sweep_fill_%0d: got ir=%b done=%b expected ir=1 done=0", i, in_ready_o, done_o);
      end
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
      @(negedge clk);
      checks++;
      if ({in_ready_o, done_o, count_o} !== {1'b0, 1'b0, 5'd3}) begin
        errors++;
        $display("FAIL sweep_hold_%0d: got ir=%b done=%b cnt=%0d expected ir=0 done=0 cnt=3",
                 c, in_ready_o, done_o, count_o);
      end
      next_cycle();
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
      @(negedge clk);
      if (done_o === 1'b1) dones++;
      checks++;
      if (done_o !== (c == 2)) begin
        errors++;
        $display("FAIL sweep_done_%0d: got %b expected %b", c, done_o, (c == 2));
      end
      if (out_valid_o) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sweep_extra: got %h expected no word", {ref_o, nbr_o});
        end else begin
          exp_w = exp_q.pop_front();
          if ({ref_o, nbr_o} !== exp_w) begin
            errors++;
            $display("FAIL sweep_data: got %h expected %h", {ref_o, nbr_o}, exp_w);
          end
        end
      end
      next_cycle();
    end
    checks++;
    if ({dones, pops, in_ready_o} !== {32'd1, 32'd3, 1'b1}) begin
      errors++;
      $display("FAIL sweep_end: got dones=%0d pops=%0d ir=%b expected 1/3/1", dones, pops, in_ready_o);
    end
  endtask

  task automatic test_null_last();
    drive(1'b1, 1'b1, 1'b1, 600, 1'b1);
    @(negedge clk);
    checks++;
    if ({done_o, out_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL nl_take: got done=%b ov=%b expected 0/0", done_o, out_valid_o);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    checks++;
    if ({done_o, out_valid_o, in_ready_o} !== 3'b100) begin
      errors++;
      $display("FAIL nl_done: got done=%b ov=%b ir=%b expected 1/0/0", done_o, out_valid_o, in_ready_o);
    end
    checks++;
    if ({acc_cnt_o, drop_cnt_o} !== {32'd0, (STATS ? 32'd1 : 32'd0)}) begin
      errors++;
      $display("FAIL nl_stats: got acc=%0d drop=%0d expected 0/%0d", acc_cnt_o, drop_cnt_o, STATS ? 1 : 0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({done_o, out_valid_o, in_ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL nl_after: got done=%b ov=%b ir=%b expected 0/0/1", done_o, out_valid_o, in_ready_o);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_filter_drop();
    test_full();
    test_back_to_back();
    test_sweep_end();
    test_null_last();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
